// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register control path.
//   USR_* : mode codes driven onto the USR select input s
//   state_e : sequencer FSM state encoding
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHL  = 2'b01;
  localparam logic [1:0] USR_SHR  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/usr_shift_sequencer.sv
// Upstream control stage for a universal shift register (USR).
// Accepts one job per valid/ready handshake, then drives the USR through
// one load cycle, N shift cycles (stretched by pause) and a done pulse.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   job handshake
//   in_data/in_dir/in_fill/in_count  job: word, 0=right 1=left, serial fill, shifts
//   pause               freezes shifting while high (SHIFT state only)
//   usr_s/usr_i/usr_sinr/usr_sinl    registered USR controls (s/I/SINR/SINL)
//   busy, done          job in progress, one-cycle completion pulse
module usr_shift_sequencer #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_dir,
  input  logic          in_fill,
  input  logic [CW-1:0] in_count,
  input  logic          pause,
  output logic [1:0]    usr_s,
  output logic [W-1:0]  usr_i,
  output logic          usr_sinr,
  output logic          usr_sinl,
  output logic          busy,
  output logic          done
);
  import usr_pkg::*;

  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  // Control state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          fill_q, fill_d;

  // Registered outputs
  logic [1:0]    usr_s_q, usr_s_d;
  logic [W-1:0]  usr_i_q, usr_i_d;
  logic          usr_sinr_q, usr_sinr_d;
  logic          usr_sinl_q, usr_sinl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_ready_q, in_ready_d;

  // High when the cycle being entered is an active shift cycle.
  logic          shift_en;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    usr_i_d  = usr_i_q;
    shift_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          // The word is captured straight into the output register so it is
          // on usr_i during the load cycle and held afterwards.
          usr_i_d = in_data;
          dir_d   = in_dir;
          fill_d  = in_fill;
          cnt_d   = (in_count > CNT_MAX) ? CNT_MAX : in_count;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d  = ST_SHIFT;
          shift_en = 1'b1;
        end
      end

      ST_SHIFT: begin
        // cnt_q counts shift cycles still owed including the one already on
        // the outputs; a paused edge neither consumes nor issues a shift,
        // so pauses only insert hold cycles.
        if (!pause) begin
          if (cnt_q == CW'(1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d    = cnt_q - CW'(1);
            shift_en = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Moore output decode from the state being entered.
    usr_s_d    = USR_HOLD;
    usr_sinr_d = 1'b0;
    usr_sinl_d = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    in_ready_d = (state_d == ST_IDLE);

    if (state_d == ST_LOAD) begin
      usr_s_d = USR_LOAD;
    end else if (shift_en) begin
      usr_s_d    = dir_d ? USR_SHL : USR_SHR;
      usr_sinl_d = dir_d & fill_d;
      usr_sinr_d = ~dir_d & fill_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      usr_s_q    <= USR_HOLD;
      usr_i_q    <= '0;
      usr_sinr_q <= 1'b0;
      usr_sinl_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      fill_q     <= fill_d;
      usr_s_q    <= usr_s_d;
      usr_i_q    <= usr_i_d;
      usr_sinr_q <= usr_sinr_d;
      usr_sinl_q <= usr_sinl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign usr_s    = usr_s_q;
  assign usr_i    = usr_i_q;
  assign usr_sinr = usr_sinr_q;
  assign usr_sinl = usr_sinl_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer. A cycle-level trace model
// (list of load/shift/hold/done events) and a behavioural 4-bit USR give
// the expected per-cycle outputs and the final shifted word.
module tb_usr_shift_sequencer;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_dir;
  logic          in_fill;
  logic [CW-1:0] in_count;
  logic          pause;
  logic [1:0]    usr_s;
  logic [W-1:0]  usr_i;
  logic          usr_sinr;
  logic          usr_sinl;
  logic          busy;
  logic          done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int accept_cnt = 0;

  usr_shift_sequencer #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dir   (in_dir),
    .in_fill  (in_fill),
    .in_count (in_count),
    .pause    (pause),
    .usr_s    (usr_s),
    .usr_i    (usr_i),
    .usr_sinr (usr_sinr),
    .usr_sinl (usr_sinl),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural USR fed by the sequencer.
  logic [W-1:0] usr_model;
  always @(posedge clk) begin
    case (usr_s)
      2'b11:   usr_model <= usr_i;
      2'b01:   usr_model <= {usr_model[W-2:0], usr_sinl};
      2'b10:   usr_model <= {usr_sinr, usr_model[W-1:1]};
      default: usr_model <= usr_model;
    endcase
  end

  always @(posedge clk) begin
    if (in_valid && in_ready) accept_cnt++;
  end

  // Expected per-cycle events after the handshake edge.
  typedef enum int {E_LOAD, E_SHIFT, E_HOLD, E_DONE} ev_e;
  ev_e exp_q[$];

  function automatic int sat(input int c);
    return (c > W) ? W : c;
  endfunction

  function automatic bit pz(input logic [31:0] pat, input int k);
    return (k >= 0 && k < 32) ? pat[k] : 1'b0;
  endfunction

  // Cycle 1 loads; cycle 2 is the first shift; every later cycle is a hold
  // if pause was high in the previous cycle, else the next shift, or DONE
  // once all n shifts have been issued.
  task automatic build_trace(input int n, input logic [31:0] pat);
    int  shifts;
    int  k;
    bit  fin;
    exp_q.delete();
    exp_q.push_back(E_LOAD);
    if (n == 0) begin
      exp_q.push_back(E_DONE);
    end else begin
      exp_q.push_back(E_SHIFT);
      shifts = 1;
      k = 3;
      fin = 0;
      while (!fin) begin
        if (pz(pat, k - 1)) exp_q.push_back(E_HOLD);
        else if (shifts == n) begin
          exp_q.push_back(E_DONE);
          fin = 1;
        end else begin
          exp_q.push_back(E_SHIFT);
          shifts++;
        end
        k++;
      end
    end
  endtask

  function automatic logic [6:0] ev_vec(input ev_e e, input logic dir, input logic fill);
    case (e)
      E_LOAD:  return {2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      E_SHIFT: return {(dir ? 2'b01 : 2'b10), ~dir & fill, dir & fill, 1'b1, 1'b0, 1'b0};
      E_HOLD:  return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      default: return {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    endcase
  endfunction

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] d, input logic dir,
                                             input logic fill, input int n);
    if (dir) return 4'((int'(d) << n) | (fill ? ((1 << n) - 1) : 0));
    else     return 4'((int'(d) >> n) | (fill ? (15 & ~(15 >> n)) : 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for an IDLE cycle with in_ready high.
  task automatic wait_ready(input string name, output bit ok);
    int t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    total_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s wait_ready: in_ready=%b required 1 within 20 cycles", name, in_ready);
      ok = 0;
    end else begin
      pass_cnt++;
      ok = 1;
    end
  endtask

  task automatic run_job(input string name, input logic [W-1:0] d, input logic dir,
                         input logic fill, input logic [CW-1:0] cnt, input logic [31:0] pat);
    bit ok;
    int n;
    logic [6:0] act;
    logic [6:0] expv;
    logic [W-1:0] ew;
    wait_ready(name, ok);
    if (!ok) return;
    n = sat(int'(cnt));
    build_trace(n, pat);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    in_fill  = fill;
    in_count = cnt;
    pause    = pz(pat, 0);
    step();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_dir   = 1'($urandom);
    in_fill  = 1'($urandom);
    in_count = CW'($urandom);
    for (int k = 1; k <= exp_q.size(); k++) begin
      act  = {usr_s, usr_sinr, usr_sinl, busy, done, in_ready};
      expv = ev_vec(exp_q[k-1], dir, fill);
      total_cnt++;
      if (act !== expv) $display("FAIL %s cycle %0d {s,sinr,sinl,busy,done,ready}: got %b required %b",
                                 name, k, act, expv);
      else pass_cnt++;
      if (exp_q[k-1] == E_LOAD) begin
        total_cnt++;
        if (usr_i !== d) $display("FAIL %s usr_i in LOAD: got %h required %h", name, usr_i, d);
        else pass_cnt++;
      end
      pause = pz(pat, k);
      step();
    end
    pause = 1'b0;
    ew = exp_word(d, dir, fill, n);
    act = {usr_s, 1'b0, 1'b0, busy, done, in_ready};
    total_cnt++;
    if (act !== 7'b00_0_0_0_0_1) $display("FAIL %s idle after done: got %b required 0000001", name, act);
    else pass_cnt++;
    total_cnt++;
    if (usr_model !== ew) $display("FAIL %s usr word: got %b required %b", name, usr_model, ew);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bit ok;
    logic [12:0] act;
    reset = 1'b1;
    step();
    step();
    act = {usr_s, usr_i, usr_sinr, usr_sinl, busy, done, in_ready, 2'b00};
    total_cnt++;
    if (act !== '0) $display("FAIL reset_values: got %b required 0", act);
    else pass_cnt++;
    reset = 1'b0;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: ready=%b busy=%b required 1 0", in_ready, busy);
    else pass_cnt++;

    // Reset in the middle of a shift phase.
    wait_ready("reset_mid", ok);
    if (!ok) return;
    in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b0; in_fill = 1'b1; in_count = 3'd4; pause = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (usr_s !== 2'b10) $display("FAIL reset_mid pre-shift: usr_s=%b required 10", usr_s);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    act = {usr_s, usr_i, usr_sinr, usr_sinl, busy, done, in_ready, 2'b00};
    total_cnt++;
    if (act !== '0) $display("FAIL reset_mid async: got %b required 0", act);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid held: done=%b busy=%b required 0 0", done, busy);
      else pass_cnt++;
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({in_ready, busy, done, usr_s} !== 5'b1_0_0_00)
        $display("FAIL reset_mid after release: {ready,busy,done,s}=%b required 10000", {in_ready, busy, done, usr_s});
      else pass_cnt++;
    end
  endtask

  task automatic test_right_shift();
    run_job("right_shift", 4'b1111, 1'b0, 1'b0, 3'd2, 32'h0);
  endtask

  task automatic test_left_shift();
    run_job("left_shift", 4'b0001, 1'b1, 1'b1, 3'd3, 32'h0);
  endtask

  task automatic test_load_only_saturation();
    run_job("load_only", 4'b1010, 1'b0, 1'b1, 3'd0, 32'h0);
    run_job("saturate7", 4'b0110, 1'b1, 1'b0, 3'd7, 32'h0);
    run_job("saturate5", 4'b1001, 1'b0, 1'b1, 3'd5, 32'h0);
  endtask

  task automatic test_pause();
    // pause high during cycles 3..5 of a 4-shift job
    run_job("pause", 4'b1100, 1'b0, 1'b1, 3'd4, 32'h0000_0038);
    // pause across LOAD and the handshake cycle has no effect
    run_job("pause_ignored", 4'b0011, 1'b1, 1'b0, 3'd2, 32'h0000_0003);
  endtask

  task automatic test_handshake();
    bit ok;
    int base;
    wait_ready("handshake", ok);
    if (!ok) return;
    in_valid = 1'b1; in_data = 4'h5; in_dir = 1'b1; in_fill = 1'b0; in_count = 3'd2; pause = 1'b0;
    base = accept_cnt;
    for (int i = 0; i < 15; i++) begin
      step();
      total_cnt++;
      if (busy === 1'b1 && in_ready !== 1'b0) $display("FAIL handshake ready_while_busy: ready=%b required 0", in_ready);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (accept_cnt - base !== 3) $display("FAIL handshake accepts: got %0d required 3", accept_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat;
    for (int j = 0; j < 20; j++) begin
      pat = '0;
      for (int b = 0; b < 12; b++) pat[b] = ($urandom_range(0, 3) == 0);
      run_job("random", W'($urandom), 1'($urandom), 1'($urandom), CW'($urandom_range(0, 7)), pat);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    in_fill = 1'b0; in_count = '0; pause = 1'b0;
    test_reset();
    test_right_shift();
    test_left_shift();
    test_load_only_saturation();
    test_pause();
    test_handshake();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
